// File: rtl/luma16x16_mode_ctrl_pkg.sv
// Shared types and constants for the 16x16 luma intra mode decision block.
package intra_pkg;

  localparam int PIX_W    = 8;
  localparam int N        = 16;
  localparam int ROWSAD_W = 12;
  localparam int SAD_W    = 16;

  // Intra 16x16 prediction modes; the numeric order is also the tie-break order.
  typedef enum logic [1:0] {
    MODE_V  = 2'd0,
    MODE_H  = 2'd1,
    MODE_DC = 2'd2
  } mode_e;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DECIDE = 2'd3
  } state_e;

endpackage

// File: rtl/luma16x16_mode_ctrl_if.sv
// Row streaming bus between the row source and the mode controller.
//
// Handshake: a row transfers on a rising edge where row_valid=1 and
// row_ready=1. The source may hold row_valid low for any number of cycles
// without penalty; the controller raises row_ready only while accumulating.
// row_idx names the row the controller expects next. dbg_state mirrors the
// controller FSM state for observation.
interface luma16x16_mode_ctrl_if
  import intra_pkg::*;
#(
  parameter int PIX_W = intra_pkg::PIX_W,
  parameter int N     = intra_pkg::N
);

  logic               row_valid;
  logic               row_ready;
  logic [N*PIX_W-1:0] mb_row;
  logic [N*PIX_W-1:0] vpred_row;
  logic [N*PIX_W-1:0] hpred_row;
  logic [N*PIX_W-1:0] dcpred_row;
  logic [3:0]         row_idx;
  state_e             dbg_state;

  modport master (
    output row_valid, mb_row, vpred_row, hpred_row, dcpred_row,
    input  row_ready, row_idx, dbg_state
  );

  modport slave (
    input  row_valid, mb_row, vpred_row, hpred_row, dcpred_row,
    output row_ready, row_idx, dbg_state
  );

endinterface

// File: rtl/luma16x16_mode_ctrl_sad_row16.sv
// Combinational sum of absolute differences across one row of N pixels.
module sad_row16
  import intra_pkg::*;
#(
  parameter int PIX_W = intra_pkg::PIX_W,
  parameter int N     = intra_pkg::N
) (
  input  logic [N*PIX_W-1:0]  i_src,
  input  logic [N*PIX_W-1:0]  i_pred,
  output logic [ROWSAD_W-1:0] o_sad
);

  // Per-pixel |src - pred| reduced into one row total; synthesis balances the sum.
  always_comb begin
    logic [PIX_W-1:0] w_a;
    logic [PIX_W-1:0] w_b;
    logic [PIX_W-1:0] w_d;
    o_sad = '0;
    for (int k = 0; k < N; k++) begin
      w_a   = i_src[k*PIX_W +: PIX_W];
      w_b   = i_pred[k*PIX_W +: PIX_W];
      w_d   = (w_a > w_b) ? (w_a - w_b) : (w_b - w_a);
      o_sad = o_sad + ROWSAD_W'(w_d);
    end
  end

endmodule

// File: rtl/luma16x16_mode_ctrl.sv
// Intra 16x16 luma mode decision: streams N rows, accumulates V/H/DC SADs
// through a two-stage pipeline and reports the cheapest legal mode.
module luma16x16_mode_ctrl
  import intra_pkg::*;
#(
  parameter int PIX_W = intra_pkg::PIX_W,
  parameter int N     = intra_pkg::N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   avail_top,
  input  logic                   avail_left,
  input  logic                   abort,
  luma16x16_mode_ctrl_if.slave   rif,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             best_mode,
  output logic [SAD_W-1:0]       best_sad
);

  localparam logic [3:0] LAST_ROW = 4'(N - 1);

  state_e              r_state;
  state_e              w_next;
  logic [3:0]          r_row_idx;
  logic                r_avail_top;
  logic                r_avail_left;
  logic [ROWSAD_W-1:0] w_sad_v, w_sad_h, w_sad_dc;
  logic [ROWSAD_W-1:0] r_rs_v, r_rs_h, r_rs_dc;
  logic                r_s1_valid;
  logic [SAD_W-1:0]    r_acc_v, r_acc_h, r_acc_dc;
  logic                r_done;
  mode_e               r_best_mode;
  logic [SAD_W-1:0]    r_best_sad;
  mode_e               w_best_mode;
  logic [SAD_W-1:0]    w_best_sad;
  logic                w_accept;
  logic                w_start_ok;
  logic                w_abort;

  // Abort only matters while busy and also blocks a start offered alongside it.
  assign w_accept   = rif.row_valid && (r_state == ST_ACCUM) && !abort;
  assign w_start_ok = start && (r_state == ST_IDLE) && !abort;
  assign w_abort    = abort && (r_state != ST_IDLE);

  sad_row16 #(.PIX_W(PIX_W), .N(N)) u_sad_v (
    .i_src(rif.mb_row), .i_pred(rif.vpred_row), .o_sad(w_sad_v)
  );
  sad_row16 #(.PIX_W(PIX_W), .N(N)) u_sad_h (
    .i_src(rif.mb_row), .i_pred(rif.hpred_row), .o_sad(w_sad_h)
  );
  sad_row16 #(.PIX_W(PIX_W), .N(N)) u_sad_dc (
    .i_src(rif.mb_row), .i_pred(rif.dcpred_row), .o_sad(w_sad_dc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_next = ST_ACCUM;
      ST_ACCUM:  if (w_accept && (r_row_idx == LAST_ROW)) w_next = ST_DRAIN;
      ST_DRAIN:  w_next = ST_DECIDE;
      ST_DECIDE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  // Row counter and neighbour availability captured at start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_row_idx    <= '0;
      r_avail_top  <= 1'b0;
      r_avail_left <= 1'b0;
    end else if (w_start_ok) begin
      r_row_idx    <= '0;
      r_avail_top  <= avail_top;
      r_avail_left <= avail_left;
    end else if (w_abort) begin
      r_row_idx <= '0;
    end else if (w_accept) begin
      r_row_idx <= r_row_idx + 4'd1;
    end
  end

  // Stage 1: capture the row SADs of each accepted row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rs_v     <= '0;
      r_rs_h     <= '0;
      r_rs_dc    <= '0;
      r_s1_valid <= 1'b0;
    end else if (w_abort || w_start_ok) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_rs_v  <= w_sad_v;
        r_rs_h  <= w_sad_h;
        r_rs_dc <= w_sad_dc;
      end
    end
  end

  // Stage 2: fold the registered row SADs into the per-mode totals.
  always_ff @(posedge clk) begin
    if (!reset || w_abort || w_start_ok) begin
      r_acc_v  <= '0;
      r_acc_h  <= '0;
      r_acc_dc <= '0;
    end else if (r_s1_valid) begin
      r_acc_v  <= r_acc_v  + SAD_W'(r_rs_v);
      r_acc_h  <= r_acc_h  + SAD_W'(r_rs_h);
      r_acc_dc <= r_acc_dc + SAD_W'(r_rs_dc);
    end
  end

  // Comparator: DC is always legal; lower mode numbers win ties, hence <=.
  always_comb begin
    w_best_mode = MODE_DC;
    w_best_sad  = r_acc_dc;
    if (r_avail_left && (r_acc_h <= w_best_sad)) begin
      w_best_mode = MODE_H;
      w_best_sad  = r_acc_h;
    end
    if (r_avail_top && (r_acc_v <= w_best_sad)) begin
      w_best_mode = MODE_V;
      w_best_sad  = r_acc_v;
    end
  end

  // Result registers: loaded on leaving DECIDE, held until the next result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_done      <= 1'b0;
      r_best_mode <= MODE_DC;
      r_best_sad  <= '0;
    end else begin
      r_done <= (r_state == ST_DECIDE) && !abort;
      if ((r_state == ST_DECIDE) && !abort) begin
        r_best_mode <= w_best_mode;
        r_best_sad  <= w_best_sad;
      end
    end
  end

  assign rif.row_ready = (r_state == ST_ACCUM);
  assign rif.row_idx   = r_row_idx;
  assign rif.dbg_state = r_state;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign best_mode     = r_best_mode;
  assign best_sad      = r_best_sad;

endmodule

// File: tb/tb_luma16x16_mode_ctrl.sv
// Directed bench for luma16x16_mode_ctrl: table of macroblocks with
// hand-computed results plus abort / reset / start-on-done sequences.
module tb_luma16x16_mode_ctrl;
  import intra_pkg::*;

  localparam int TPW = 8;
  localparam int TN  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic start, avail_top, avail_left, abort;
  logic busy, done;
  logic [1:0]  best_mode;
  logic [15:0] best_sad;

  always #5 clk = ~clk;

  luma16x16_mode_ctrl_if #(.PIX_W(TPW), .N(TN)) rif ();

  luma16x16_mode_ctrl #(.PIX_W(TPW), .N(TN)) dut (
    .clk(clk), .reset(reset), .start(start), .avail_top(avail_top),
    .avail_left(avail_left), .abort(abort), .rif(rif), .busy(busy),
    .done(done), .best_mode(best_mode), .best_sad(best_sad)
  );

  // ---------------- vector table ----------------
  typedef struct {
    int src; int vp; int hp; int dcp;
    bit ramp; bit at; bit al; bit gap; bit mid_start; bit chain;
    int exp_mode; int exp_sad; int exp_accum;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  int  checks = 0;
  int  errors = 0;
  bit  prestarted = 1'b0;
  int  last_mode = 2;
  int  last_sad  = 0;

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TN*TPW-1:0] build_row(input int base, input bit ramp);
    logic [TN*TPW-1:0] r;
    r = '0;
    for (int j = 0; j < TN; j++) r[j*TPW +: TPW] = 8'((base + (ramp ? j : 0)) & 255);
    return r;
  endfunction

  task automatic drive_rows(input int src, input int vp, input int hp, input int dcp, input bit ramp);
    rif.mb_row     = build_row(src, ramp);
    rif.vpred_row  = build_row(vp, 1'b0);
    rif.hpred_row  = build_row(hp, 1'b0);
    rif.dcpred_row = build_row(dcp, 1'b0);
  endtask

  // Runs one macroblock from vector k and checks result, latency and pulse.
  task automatic run_mb(input int k);
    vec_t v;
    int sent, cyc, accum_cyc, wait_cyc;
    bit vld, got;
    v = vecs[k];
    if (!prestarted) begin
      start = 1'b1; avail_top = v.at; avail_left = v.al;
      tick();
    end
    prestarted = 1'b0;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    sent = 0; cyc = 0; accum_cyc = 0;
    while (sent < TN && cyc < 200) begin
      vld = v.gap ? cyc[0] : 1'b1;
      rif.row_valid = vld;
      if (vld) drive_rows(v.src, v.vp, v.hp, v.dcp, v.ramp);
      else     drive_rows(v.src + 77, v.vp + 131, v.hp + 29, v.dcp + 61, 1'b1);
      if (v.mid_start && cyc == 5) begin
        start = 1'b1; avail_top = ~v.at; avail_left = ~v.al;
      end else begin
        start = 1'b0;
      end
      if (rif.row_ready) accum_cyc++;
      if (vld) chk("row_idx", rif.row_idx, sent);
      tick();
      if (vld) sent++;
      cyc++;
    end
    start = 1'b0;
    rif.row_valid = 1'b0;
    chk("accum_cycles", accum_cyc, v.exp_accum);
    // One edge past the last acceptance; done belongs two edges later (cycle c+3).
    wait_cyc = 0; got = 1'b0;
    while (!got && wait_cyc < 10) begin
      if (done) got = 1'b1;
      else begin
        tick();
        wait_cyc++;
      end
    end
    chk("done_seen", got, 1);
    chk("done_latency", wait_cyc, 2);
    chk("best_mode", best_mode, v.exp_mode);
    chk("best_sad", best_sad, v.exp_sad);
    chk("busy_in_done", busy, 0);
    if (v.chain) begin
      start = 1'b1; avail_top = vecs[k+1].at; avail_left = vecs[k+1].al;
      prestarted = 1'b1;
    end
    tick();
    if (!v.chain) start = 1'b0;
    chk("done_pulse_width", done, 0);
    chk("best_mode_hold", best_mode, v.exp_mode);
    chk("best_sad_hold", best_sad, v.exp_sad);
    chk("busy_after_done", busy, v.chain);
    last_mode = v.exp_mode;
    last_sad  = v.exp_sad;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ndone;
    //            src  vp   hp   dcp ramp at al gap mid chain mode sad   accum
    vecs[0] = '{100, 100, 90, 110, 0, 1, 1, 0, 0, 0, 0, 0,     16};
    vecs[1] = '{50,  60,  40, 55,  0, 0, 1, 0, 0, 0, 2, 1280,  16};
    vecs[2] = '{10,  11,  9,  11,  0, 1, 1, 0, 0, 0, 0, 256,   16};
    vecs[3] = '{100, 100, 90, 110, 0, 1, 1, 1, 1, 0, 0, 0,     32};
    vecs[4] = '{20,  0,   23, 17,  0, 0, 1, 0, 0, 1, 1, 768,   16};
    vecs[5] = '{200, 200, 200, 0,  0, 0, 0, 0, 0, 1, 2, 51200, 16};
    vecs[6] = '{255, 0,   0,  0,   0, 1, 1, 0, 0, 0, 0, 65280, 16};
    vecs[7] = '{0,   5,   3,  4,   0, 1, 1, 0, 0, 0, 1, 768,   16};
    vecs[8] = '{0,   0,   15, 8,   1, 1, 1, 0, 0, 0, 2, 1024,  16};

    reset = 1'b0; start = 1'b0; avail_top = 1'b0; avail_left = 1'b0; abort = 1'b0;
    rif.row_valid = 1'b0;
    drive_rows(0, 0, 0, 0, 1'b0);
    repeat (3) tick();

    // Reset state.
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", rif.row_ready, 0);
    chk("rst_row_idx", rif.row_idx, 0);
    chk("rst_best_mode", best_mode, 2);
    chk("rst_best_sad", best_sad, 0);
    chk("rst_state", rif.dbg_state, ST_IDLE);
    reset = 1'b1;
    tick();

    // Table-driven macroblocks.
    for (int k = 0; k < NV; k++) run_mb(k);
    repeat (2) tick();

    // Abort after row 7 with a row offered in the same cycle.
    start = 1'b1; avail_top = 1'b1; avail_left = 1'b1;
    tick();
    start = 1'b0;
    drive_rows(0, 255, 255, 255, 1'b0);
    rif.row_valid = 1'b1;
    repeat (8) tick();
    chk("abort_pre_row_idx", rif.row_idx, 8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    rif.row_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", rif.row_ready, 0);
    chk("abort_row_idx", rif.row_idx, 0);
    chk("abort_best_mode", best_mode, last_mode);
    chk("abort_best_sad", best_sad, last_sad);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    run_mb(0);

    // Abort with start in IDLE stays IDLE; abort alone in IDLE is harmless.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_start_idle", busy, 0);
    tick();
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_mode", best_mode, last_mode);

    // Reset mid-accumulation.
    start = 1'b1; avail_top = 1'b1; avail_left = 1'b1;
    tick();
    start = 1'b0;
    drive_rows(10, 11, 9, 11, 1'b0);
    rif.row_valid = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    rif.row_valid = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_mode", best_mode, 2);
    chk("mid_rst_sad", best_sad, 0);
    chk("mid_rst_row_idx", rif.row_idx, 0);
    chk("mid_rst_ready", rif.row_ready, 0);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("mid_rst_no_done", ndone, 0);
    run_mb(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/luma16x16_mode_ctrl.md
LUMA16X16_MODE_CTRL -- requirements
Module: luma16x16_mode_ctrl

Interface
REQ-001 Parameter PIX_W, default 8: pixel and predictor sample width in bits.
REQ-002 Parameter N, default 16: macroblock edge in pixels, which sets the row count and the pixels per row.
REQ-003 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port start, input, 1: begin one macroblock mode decision.
REQ-006 Port avail_top, input, 1: top neighbours exist, so vertical (V) mode is legal; sampled with start.
REQ-007 Port avail_left, input, 1: left neighbours exist, so horizontal (H) mode is legal; sampled with start.
REQ-008 Port abort, input, 1: cancel the decision in progress.
REQ-009 Port row_valid, input, 1: row data on the four row buses is valid.
REQ-010 Port row_ready, output, 1: controller accepts a row this cycle.
REQ-011 Port mb_row, input, N*PIX_W: source pixels of the current row, pixel 0 in the LSBs.
REQ-012 Port vpred_row, input, N*PIX_W: V-mode predictor row.
REQ-013 Port hpred_row, input, N*PIX_W: H-mode predictor row.
REQ-014 Port dcpred_row, input, N*PIX_W: DC-mode predictor row.
REQ-015 Port row_idx, output, 4: index of the next row expected, 0..15.
REQ-016 Port busy, output, 1: high whenever the FSM is not IDLE.
REQ-017 Port done, output, 1: one-cycle pulse; best_mode and best_sad are valid in that cycle.
REQ-018 Port best_mode, output, 2: winning mode, 0=V, 1=H, 2=DC.
REQ-019 Port best_sad, output, 16: SAD of the winning mode.

Function
REQ-020 The FSM SHALL have exactly four states, IDLE, ACCUM, DRAIN and DECIDE, with these transitions: IDLE->ACCUM on start; ACCUM->DRAIN when row 15 is accepted; DRAIN->DECIDE unconditionally; DECIDE->IDLE unconditionally.
REQ-021 start SHALL be ignored unless the FSM is in IDLE.
REQ-022 On an accepted start, the controller SHALL clear the three accumulators, reset row_idx to 0, and latch avail_top and avail_left.
REQ-023 row_ready SHALL equal 1 only in ACCUM.
REQ-024 A row SHALL be accepted on a rising edge where row_valid=1 and row_ready=1; row_valid=0 stalls without penalty, and row_idx increments by one per accepted row.
REQ-025 Stage 1, on the acceptance edge: register, per mode, the row SAD = sum over the N pixels of |mb - pred|, computed unsigned and stored in 12 bits (maximum 4080).
REQ-026 Stage 2, on the following edge: add each registered row SAD into its 16-bit mode accumulator (maximum 65280, so no overflow).
REQ-027 Stage 2 SHALL accumulate only when stage 1 holds a newly accepted row, tracked by a valid flag.
REQ-028 Accumulation SHALL be fully pipelined so back-to-back rows are accepted every cycle, giving a minimum of 16 cycles in ACCUM.
REQ-029 In DECIDE, the candidates SHALL be: V if avail_top, H if avail_left, and DC always.
REQ-030 best_mode SHALL be the candidate with the lowest SAD, with ties broken toward the lower mode number.
REQ-031 best_mode and best_sad SHALL be registered on the DECIDE->IDLE edge, and done SHALL be 1 for exactly that following cycle.
REQ-032 Latency: if row 15 is accepted in cycle c, done SHALL be high in cycle c+3.
REQ-033 best_mode and best_sad SHALL hold their values until the next done.
REQ-034 A start in the cycle where done=1 SHALL be accepted, since the FSM is in IDLE; the new run's clearing SHALL NOT disturb the outputs just delivered.
REQ-035 abort while busy SHALL return the FSM to IDLE on the next edge, with no done pulse, the accumulators cleared and the outputs unchanged.
REQ-036 abort has priority over a row acceptance in the same cycle.
REQ-037 abort in IDLE SHALL be a no-op, and abort together with start in IDLE SHALL leave the FSM in IDLE.

Reset
REQ-038 While reset=0 at a rising edge: FSM->IDLE; row_idx=0; busy=0; done=0; row_ready=0; best_mode=2 (DC); best_sad=0; accumulators, row-SAD registers and the stage valid flag=0.
REQ-039 Reset asserted mid-run SHALL behave as REQ-038, with no done pulse.

Structure
REQ-040 Package intra_pkg SHALL hold the mode enum (V=0, H=1, DC=2), PIX_W, N, ROWSAD_W=12, SAD_W=16, and the FSM state typedef.
REQ-041 A sub-module sad_row16 SHALL be used: a combinational N-pixel absolute-difference adder tree, instantiated once per mode (three instances).
REQ-042 The controller contains only the FSM, counter, pipeline registers, accumulators and comparator.

Verification
REQ-043 Scenario 1: all sources 100, V pred 100, H pred 90, DC pred 110, both avail=1, 16 back-to-back rows -> done at c+3, best_mode=0, best_sad=0.
REQ-044 Scenario 2: sources 50, V pred 60, H pred 40, DC pred 55, avail_top=0 -> V excluded; H SAD=2560 and DC SAD=1280, so best_mode=2, best_sad=1280.
REQ-045 Scenario 3: equal SAD 256 for all modes, both avail=1 -> best_mode=0 (tie rule).
REQ-046 Scenario 4: row_valid toggled 1/0 each cycle -> 32 cycles in ACCUM, row_idx steps 0..15, same result as back-to-back.
REQ-047 Scenario 5: abort after row 7, then a new start with valid data -> no done from the aborted run; the new run's result is independent of the aborted rows.
REQ-048 Scenario 6: reset=0 asserted mid-ACCUM -> next cycle busy=0, done=0, best_mode=2, best_sad=0; a start in the same cycle as done is accepted.
